mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and resolves taken branches. It runs load/store transactions on a req/ack data-memory bus and stalls upstream stages while a transaction is outstanding. It then drives the MEM/WB pipeline register feeding write-back.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_wb.sv | 46 ++++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, write-back control bit positions and MEM-stage
//               FSM state encoding for the RISC-V pipeline.
// Revision    : 1.0
// ============================================================================
package mem_stage_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int WB_CTRL        = 2;

    localparam int WB_REG_WRITE   = 1;
    localparam int WB_MEM_TO_REG  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Data-memory req/ack bus between the MEM stage and memory.
// Revision    : 1.0
// ============================================================================
interface mem_stage_if
    import mem_stage_pkg::*;
();
    logic                 dmem_req;
    logic                 dmem_we;
    logic [CPU_WIDTH-1:0] dmem_addr;
    logic [CPU_WIDTH-1:0] dmem_wdata;
    logic                 dmem_ack;
    logic [CPU_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb
// Description : MEM/WB pipeline register with load-enable and bubble insert.
// Revision    : 1.0
// ============================================================================
module mem_wb
    import mem_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      load_en,
    input  logic                      bubble,
    input  logic [WB_CTRL-1:0]        wb_d,
    input  logic [CPU_WIDTH-1:0]      rdata_d,
    input  logic [CPU_WIDTH-1:0]      alu_d,
    input  logic [REG_ADDR_WIDTH-1:0] wreg_d,
    input  logic [CPU_WIDTH-1:0]      pc_d,
    output logic [WB_CTRL-1:0]        wb_q,
    output logic [CPU_WIDTH-1:0]      rdata_q,
    output logic [CPU_WIDTH-1:0]      alu_q,
    output logic [REG_ADDR_WIDTH-1:0] wreg_q,
    output logic [CPU_WIDTH-1:0]      pc_q
);

    // A bubble only kills the control bits; data fields keep their old values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
            pc_q    <= '0;
        end else if (bubble) begin
            wb_q    <= '0;
        end else if (load_en) begin
            wb_q    <= wb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            wreg_q  <= wreg_d;
            pc_q    <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : RISC-V MEM stage: branch resolve, req/ack load/store with
//               timeout, pipeline stall and MEM/WB register.
// Revision    : 1.0
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [WB_CTRL-1:0]        wb_i,
    input  logic                      branch_i,
    input  logic                      mem_write_i,
    input  logic                      mem_read_i,
    input  logic [CPU_WIDTH-1:0]      alu_result_i,
    input  logic                      zero_i,
    input  logic [CPU_WIDTH-1:0]      read_2_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] wreg_addr_i,
    input  logic [CPU_WIDTH-1:0]      pc_shift_i,
    input  logic [CPU_WIDTH-1:0]      pc_trans_i,
    mem_stage_if.master               dmem,
    output logic                      mem_stall_o,
    output logic                      branch_taken_o,
    output logic [CPU_WIDTH-1:0]      branch_target_o,
    output logic                      bus_err_o,
    output logic [WB_CTRL-1:0]        wb_o,
    output logic [CPU_WIDTH-1:0]      mem_rdata_o,
    output logic [CPU_WIDTH-1:0]      alu_result_o,
    output logic [REG_ADDR_WIDTH-1:0] wreg_addr_o,
    output logic [CPU_WIDTH-1:0]      pc_trans_o
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e               r_state;
    state_e               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_req;
    logic                 r_we;
    logic [CPU_WIDTH-1:0] r_addr;
    logic [CPU_WIDTH-1:0] r_wdata;
    logic [CPU_WIDTH-1:0] r_load_buf;
    logic                 r_err;
    logic                 r_bus_err;

    logic                 w_access;
    logic                 w_issue;
    logic                 w_ack_ok;
    logic                 w_timeout;
    logic                 w_stall;
    logic [WB_CTRL-1:0]   w_wb_d;
    logic [CPU_WIDTH-1:0] w_rdata_d;

    assign w_access = mem_read_i | mem_write_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An ack in the final allowed cycle wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_ack_ok     = 1'b0;
        w_timeout    = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_stall      = 1'b1;
                    w_issue      = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                w_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    w_ack_ok     = 1'b1;
                    w_state_next = DONE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_load_buf <= '0;
            r_err      <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_issue) begin
                r_req   <= 1'b1;
                r_we    <= mem_write_i;
                r_addr  <= alu_result_i;
                r_wdata <= read_2_data_i;
                r_err   <= 1'b0;
            end else if (w_ack_ok) begin
                r_req      <= 1'b0;
                r_we       <= 1'b0;
                r_load_buf <= dmem.dmem_rdata;
            end else if (w_timeout) begin
                r_req      <= 1'b0;
                r_we       <= 1'b0;
                r_load_buf <= '0;
                r_err      <= 1'b1;
            end
            if (r_state == ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // A bus-errored instruction must not update the register file.
    always_comb begin
        w_wb_d = wb_i;
        if ((r_state == DONE) && r_err) begin
            w_wb_d[WB_REG_WRITE] = 1'b0;
        end
    end

    assign w_rdata_d = (r_state == DONE) ? r_load_buf : '0;

    mem_wb u_mem_wb (
        .clk     (clk),
        .rstn    (rstn),
        .load_en (~w_stall),
        .bubble  (w_stall),
        .wb_d    (w_wb_d),
        .rdata_d (w_rdata_d),
        .alu_d   (alu_result_i),
        .wreg_d  (wreg_addr_i),
        .pc_d    (pc_trans_i),
        .wb_q    (wb_o),
        .rdata_q (mem_rdata_o),
        .alu_q   (alu_result_o),
        .wreg_q  (wreg_addr_o),
        .pc_q    (pc_trans_o)
    );

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;

    assign mem_stall_o     = w_stall;
    assign branch_taken_o  = branch_i & zero_i & (r_state == IDLE);
    assign branch_target_o = pc_shift_i;
    assign bus_err_o       = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage against a transaction-level
//               timing/result model with randomized instructions and latencies.
// Revision    : 1.0
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  wb_i;
    logic        branch_i, mem_write_i, mem_read_i, zero_i;
    logic [31:0] alu_result_i, read_2_data_i, pc_shift_i, pc_trans_i;
    logic [4:0]  wreg_addr_i;
    logic        mem_stall_o, branch_taken_o, bus_err_o;
    logic [31:0] branch_target_o, mem_rdata_o, alu_result_o, pc_trans_o;
    logic [1:0]  wb_o;
    logic [4:0]  wreg_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_if dmem_bus ();

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .wb_i            (wb_i),
        .branch_i        (branch_i),
        .mem_write_i     (mem_write_i),
        .mem_read_i      (mem_read_i),
        .alu_result_i    (alu_result_i),
        .zero_i          (zero_i),
        .read_2_data_i   (read_2_data_i),
        .wreg_addr_i     (wreg_addr_i),
        .pc_shift_i      (pc_shift_i),
        .pc_trans_i      (pc_trans_i),
        .dmem            (dmem_bus),
        .mem_stall_o     (mem_stall_o),
        .branch_taken_o  (branch_taken_o),
        .branch_target_o (branch_target_o),
        .bus_err_o       (bus_err_o),
        .wb_o            (wb_o),
        .mem_rdata_o     (mem_rdata_o),
        .alu_result_o    (alu_result_o),
        .wreg_addr_o     (wreg_addr_o),
        .pc_trans_o      (pc_trans_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic        br, z, mr, mw;
        logic [31:0] alu, wd, ps, pt;
        logic [4:0]  rd;
        int          delay;   // idle ACCESS cycles before ack
        logic [31:0] rdata;
    } instr_t;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic instr_t make_instr(input logic [1:0] wb, input logic br, input logic z,
                                          input logic mr, input logic mw, input logic [31:0] alu,
                                          input logic [31:0] wd, input logic [4:0] rd,
                                          input int delay, input logic [31:0] rdata);
        instr_t t;
        t.wb = wb; t.br = br; t.z = z; t.mr = mr; t.mw = mw;
        t.alu = alu; t.wd = wd; t.rd = rd; t.delay = delay; t.rdata = rdata;
        t.ps = $urandom; t.pt = $urandom;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        wb_i = t.wb; branch_i = t.br; zero_i = t.z; mem_read_i = t.mr; mem_write_i = t.mw;
        alu_result_i = t.alu; read_2_data_i = t.wd; wreg_addr_i = t.rd;
        pc_shift_i = t.ps; pc_trans_i = t.pt;
    endtask

    task automatic check_wb(input instr_t t, input logic [1:0] exp_wb, input logic [31:0] exp_rdata);
        check_val("wb_o", 32'(wb_o), 32'(exp_wb));
        check_val("mem_rdata_o", mem_rdata_o, exp_rdata);
        check_val("alu_result_o", alu_result_o, t.alu);
        check_val("wreg_addr_o", 32'(wreg_addr_o), 32'(t.rd));
        check_val("pc_trans_o", pc_trans_o, t.pt);
    endtask

    // Call just after a rising edge; returns just after the edge that retires t.
    task automatic run_instr(input instr_t t);
        bit timed_out;
        int n_acc;
        timed_out = (t.delay + 1 > TIMEOUT);
        n_acc     = timed_out ? TIMEOUT : t.delay + 1;
        drive(t);
        if (!(t.mr || t.mw)) begin
            @(negedge clk);
            check_val("stall_alu", 32'(mem_stall_o), 32'd0);
            check_val("req_alu", 32'(dmem_bus.dmem_req), 32'd0);
            check_val("br_taken", 32'(branch_taken_o), 32'(t.br & t.z));
            check_val("br_target", branch_target_o, t.ps);
            @(posedge clk); #1;
            check_wb(t, t.wb, 32'd0);
        end else begin
            for (int c = 0; c <= n_acc + 1; c++) begin
                @(negedge clk);
                check_val("stall", 32'(mem_stall_o), 32'(c <= n_acc));
                check_val("req", 32'(dmem_bus.dmem_req), 32'(c >= 1 && c <= n_acc));
                check_val("bus_err", 32'(bus_err_o), 32'(timed_out && c == n_acc + 1));
                check_val("br_taken_mem", 32'(branch_taken_o), 32'((c == 0) & t.br & t.z));
                if (c >= 1) check_val("bubble_wb", 32'(wb_o), 32'd0);
                if (c >= 1 && c <= n_acc) begin
                    check_val("we", 32'(dmem_bus.dmem_we), 32'(t.mw));
                    check_val("addr", dmem_bus.dmem_addr, t.alu);
                    check_val("wdata", dmem_bus.dmem_wdata, t.wd);
                end
                dmem_bus.dmem_rdata = $urandom;
                if (!timed_out && c == n_acc) begin
                    dmem_bus.dmem_ack   = 1'b1;
                    dmem_bus.dmem_rdata = t.rdata;
                end
                @(posedge clk); #1;
                dmem_bus.dmem_ack = 1'b0;
            end
            check_wb(t, timed_out ? {1'b0, t.wb[WB_MEM_TO_REG]} : t.wb,
                     timed_out ? 32'd0 : t.rdata);
        end
    endtask

    initial begin
        instr_t t;
        drive(make_instr(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0, 32'd0));
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_wb", 32'(wb_o), 32'd0);
        check_val("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        check_val("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
        check_val("rst_bus_err", 32'(bus_err_o), 32'd0);
        check_val("rst_rdata", mem_rdata_o, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of an outstanding load
        drive(make_instr(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'd0, 5'd3, 99, 32'd0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("pre_rst_req", 32'(dmem_bus.dmem_req), 32'd1);
        rstn = 1'b0;
        #1;
        check_val("mid_rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        check_val("mid_rst_wb", 32'(wb_o), 32'd0);
        drive(make_instr(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0, 32'd0));
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_instr(make_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_00A5, 32'd0, 5'd7, 0, 32'd0));
        run_instr(make_instr(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 5'd9, 0, 32'hDEAD_BEEF));
        run_instr(make_instr(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h1234, 5'd0, 3, 32'd0));
        run_instr(make_instr(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'd0, 5'd4, 40, 32'h5555_AAAA));
        run_instr(make_instr(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h404, 32'd0, 5'd5, TIMEOUT - 1, 32'hCAFE_F00D));
        run_instr(make_instr(2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h77, 5'd6, 1, 32'h1111_2222));
        t = make_instr(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
        t.ps = 32'h40;
        run_instr(t);
        t.z = 1'b0;
        run_instr(t);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            int d;
            logic acc;
            d   = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : int'($urandom_range(12, 18));
            acc = ($urandom_range(0, 1) == 1);
            t = make_instr(2'($urandom), 1'($urandom), 1'($urandom),
                           acc & 1'($urandom), 1'b0, $urandom, $urandom, 5'($urandom), d, $urandom);
            if (acc && !t.mr) t.mw = 1'b1;
            else if (acc) t.mw = 1'($urandom);
            run_instr(t);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
